// File: rtl/param_data_mem.sv
// Parametrised data memory with byte-enable writes and a post-reset clear sequencer.
// Optional registered (write-first) or asynchronous read port; out-of-range accesses are flagged on oob.
module param_data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int RD_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     a,
  input  logic [DATA_W-1:0]     d,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     dpra,
  output logic [DATA_W-1:0]     dpo,
  input  logic                  clr_req,
  output logic                  rdy,
  output logic                  oob
);

  localparam int                NB        = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_oob;

  logic              w_ready;
  logic              w_a_ok;
  logic              w_rd_ok;
  logic              w_wr_en;
  logic              w_clr_wr;
  logic [DATA_W-1:0] w_rd_word;

  // The extra leading bit keeps the range compare exact when DEPTH == 2**ADDR_W.
  assign w_ready   = (r_state == ST_READY);
  assign w_a_ok    = ({1'b0, a} < DEPTH_L);
  assign w_rd_ok   = ({1'b0, dpra} < DEPTH_L);
  assign w_wr_en   = w_ready && we && w_a_ok;
  assign w_clr_wr  = !w_ready && rst_n;
  assign w_rd_word = w_rd_ok ? r_mem[dpra] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_oob     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_oob     <= w_ready && ((we && !w_a_ok) || !w_rd_ok);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_ptr == LAST_ADDR) begin
          w_state_nxt   = ST_READY;
          w_clr_ptr_nxt = '0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (clr_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  // No reset on the array so it can map onto RAM; the sequencer does the zeroing.
  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) r_mem[a][8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [DATA_W-1:0] r_dpo;
      logic [DATA_W-1:0] w_merged;

      always_comb begin
        w_merged = r_mem[a];
        for (int i = 0; i < NB; i++) begin
          if (be[i]) w_merged[8*i +: 8] = d[8*i +: 8];
        end
      end

      // Same-address write bypasses the array so the read sees the merged word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dpo <= '0;
        end else if (!w_ready) begin
          r_dpo <= '0;
        end else if (w_wr_en && (a == dpra)) begin
          r_dpo <= w_merged;
        end else begin
          r_dpo <= w_rd_word;
        end
      end

      assign dpo = w_ready ? r_dpo : '0;
    end else begin : g_rd_async
      assign dpo = w_ready ? w_rd_word : '0;
    end
  endgenerate

  assign rdy = w_ready;
  assign oob = r_oob;

endmodule
